// File: rtl/fetch_if.sv
// Fetch-side bus bundle: redirect, instruction memory port and decode handoff.
// Master is the fetch unit; slave is the surrounding core/memory.
package fetch_pkg;
  typedef struct packed {
`ifdef SIMULATION
    logic [31:0] simid;
`endif
    logic [31:0] raw;
  } t_rv_instr;
endpackage

interface fetch_if;
  import fetch_pkg::*;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_de0;
  logic        valid_de0;
  t_rv_instr   instr_de0;
  logic [31:0] pc_de0;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  stall_de0,
    output imem_req_valid, imem_req_addr,
    output valid_de0, instr_de0, pc_de0
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output stall_de0,
    input  imem_req_valid, imem_req_addr,
    input  valid_de0, instr_de0, pc_de0
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding imem reader feeding an in-order
// instruction queue whose head is presented to decode.
module fetch
  import fetch_pkg::*;
#(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(IQ_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    t_rv_instr   instr;
    logic [31:0] pc;
  } entry_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   rpc;
  logic          redir, rsp, hs;
  logic          push, pop, full, empty;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count;
  entry_t        mem [IQ_DEPTH];
  entry_t        entry_n;

  assign redir = bus.redirect_valid;
  assign rsp   = bus.imem_rsp_valid;
  assign rpc   = bus.redirect_pc & ~32'h3;
  assign full  = (count == FULL);
  assign empty = (count == '0);

  assign bus.imem_req_valid = (state == REQ) && !full;
  assign bus.imem_req_addr  = pc;
  assign hs = bus.imem_req_valid && bus.imem_req_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redir) pc_n = rpc;
        if (hs) state_n = redir ? DROP : WAIT;
      end
      WAIT: begin
        if (rsp) begin
          state_n = REQ;
          if (redir) begin
            pc_n = rpc;
          end else begin
            push = 1'b1;
            pc_n = pc + 32'd4;
          end
        end else if (redir) begin
          pc_n    = rpc;
          state_n = DROP;
        end
      end
      DROP: begin
        if (redir) pc_n = rpc;
        if (rsp) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

`ifdef SIMULATION
  logic [31:0] simid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) simid <= '0;
    else if (push) simid <= simid + 32'd1;
  end
`endif

  always_comb begin
    entry_n           = '0;
    entry_n.instr.raw = bus.imem_rsp_data;
`ifdef SIMULATION
    entry_n.instr.simid = simid;
`endif
    entry_n.pc        = pc;
  end

  assign bus.valid_de0 = !empty && !redir;
  assign bus.instr_de0 = empty ? '0 : mem[rd].instr;
  assign bus.pc_de0    = empty ? '0 : mem[rd].pc;
  assign pop = bus.valid_de0 && !bus.stall_de0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (redir) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= entry_n;
  end

`ifdef SIMULATION
  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(push && full));
  a_rsp_state: assert property (
    @(posedge clk) disable iff (reset)
    rsp |-> (state == WAIT || state == DROP));
  a_align: assert property (
    @(posedge clk) disable iff (reset)
    redir |-> (bus.redirect_pc[1:0] == 2'b00))
    else $warning("unaligned redirect_pc");
`endif

endmodule
